bcd_countdown_timer: RTL

- Parametrised countdown timer core for the egg-timer product line; replaces the fixed 4-digit mm:ss board logic with a reusable block.
- Holds a preset of DIGITS BCD digits and counts it down once per second.
- Supports pause/resume and a latched alarm with a flashing LED output.
- Generates its own one-second and flash timebases from CLOCK_50. The board top level only wires keys and switches in, and 7-segment decoders and LEDs out.

---
 rtl/bcd_countdown_timer_pkg.sv | 39 +++
 rtl/bcd_countdown_timer_if.sv | 37 +++
 rtl/bcd_down_digit.sv | 43 ++++
 rtl/bcd_countdown_timer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// +--------------------------------------------------------------------------+
// | Package : bcd_timer_pkg                                                  |
// | Purpose : State encoding and BCD digit helpers shared by the countdown   |
// |           timer top level and its per-digit down counter.                |
// | Contents: state_t (3-bit FSM encoding), digit_max(), bcd_clamp(),        |
// |           bcd_dec().                                                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package bcd_timer_pkg;

  localparam int c_bcd_w = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  // Tens-of-seconds and tens-of-minutes digits roll over at 5; everything
  // else (units, hours and beyond) is plain decimal.
  function automatic logic [3:0] digit_max(input int idx);
    return ((idx < 4) && ((idx % 2) == 1)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] max);
    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
// +--------------------------------------------------------------------------+
// | Interface : bcd_countdown_timer_if                                       |
// | Purpose   : Command and status bundle of the countdown timer.            |
// | Ports     : master drives load/preset_in/start/pause/clear and observes  |
// |             count/preset/running/done/alarm/leds; slave is the timer.    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4,
  parameter int LED_W  = 10
);
  logic                  load;
  logic [4*DIGITS-1:0]   preset_in;
  logic                  start;
  logic                  pause;
  logic                  clear;
  logic [4*DIGITS-1:0]   count;
  logic [4*DIGITS-1:0]   preset;
  logic                  running;
  logic                  done;
  logic                  alarm;
  logic [LED_W-1:0]      leds;

  modport master (
    output load, preset_in, start, pause, clear,
    input  count, preset, running, done, alarm, leds
  );

  modport slave (
    input  load, preset_in, start, pause, clear,
    output count, preset, running, done, alarm, leds
  );
endinterface

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// +--------------------------------------------------------------------------+
// | Module  : bcd_down_digit                                                 |
// | Purpose : One BCD digit of a cascaded down counter. Decrements when a    |
// |           borrow arrives from below, reloading to MAX on underflow.      |
// | Ports   : CLOCK_50, RESET_N (sync, active low), borrow_in, load,         |
// |           load_val[3:0] -> digit[3:0], borrow_out.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_down_digit
  import bcd_timer_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  wire logic       CLOCK_50,
  input  wire logic       RESET_N,
  input  wire logic       borrow_in,
  input  wire logic       load,
  input  wire logic [3:0] load_val,
  output logic      [3:0] digit,
  output logic            borrow_out
);

  logic [3:0] r_digit;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= load_val;
    end else if (borrow_in) begin
      r_digit <= bcd_dec(r_digit, MAX);
    end
  end

  assign digit      = r_digit;
  // A digit sitting at zero passes the borrow upward as it reloads.
  assign borrow_out = borrow_in && (r_digit == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// +--------------------------------------------------------------------------+
// | Module  : bcd_countdown_timer                                            |
// | Purpose : Presettable BCD countdown timer with pause/resume and a        |
// |           latched, flashing alarm. Own tick and flash prescalers.        |
// | Ports   : CLOCK_50, RESET_N (sync, active low), bus (slave): commands    |
// |           load/preset_in/start/pause/clear, status count/preset/         |
// |           running/done/alarm/leds.                                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int FLASH_DIV = 25000000,
  parameter int LED_W     = 10
) (
  input  wire logic       CLOCK_50,
  input  wire logic       RESET_N,
  bcd_countdown_timer_if.slave bus
);

  localparam int c_cnt_w   = 4 * DIGITS;
  localparam int c_tick_w  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int c_flash_w = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_flash_w-1:0] c_flash_last = c_flash_w'(FLASH_DIV - 1);

  state_t                r_state, w_state_nx;
  logic [c_tick_w-1:0]   r_tick, w_tick_nx;
  logic [c_flash_w-1:0]  r_fdiv, w_fdiv_nx;
  logic                  r_flash, w_flash_nx;
  logic                  r_done, w_done_nx;
  logic [c_cnt_w-1:0]    r_preset, w_preset_nx;

  logic [c_cnt_w-1:0]    w_count;
  logic [c_cnt_w-1:0]    w_clamped;
  logic [c_cnt_w-1:0]    w_fsm_load_val, w_load_val;
  logic                  w_fsm_load, w_load_en;
  logic                  w_dec_en;
  logic [DIGITS:0]       w_borrow;
  logic                  w_nz, w_one, w_can_load;

  assign w_borrow[0] = w_dec_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_clamped[4*i +: 4] = bcd_clamp(bus.preset_in[4*i +: 4], digit_max(i));

    bcd_down_digit #(.MAX(digit_max(i))) u_digit (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .borrow_in  (w_borrow[i]),
      .load       (w_load_en),
      .load_val   (w_load_val[4*i +: 4]),
      .digit      (w_count[4*i +: 4]),
      .borrow_out (w_borrow[i+1])
    );
  end

  assign w_nz       = |w_count;
  assign w_one      = (w_count == c_cnt_w'(1));
  assign w_can_load = (r_state == ST_IDLE) || (r_state == ST_READY) || (r_state == ST_PAUSE);

  // A borrow escaping the top digit would wrap the count to all-max; force
  // it back to zero instead so the count floors at 0.
  assign w_load_en  = w_fsm_load | w_borrow[DIGITS];
  assign w_load_val = w_borrow[DIGITS] ? '0 : w_fsm_load_val;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_tick   <= '0;
      r_fdiv   <= '0;
      r_flash  <= 1'b0;
      r_done   <= 1'b0;
      r_preset <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_tick   <= w_tick_nx;
      r_fdiv   <= w_fdiv_nx;
      r_flash  <= w_flash_nx;
      r_done   <= w_done_nx;
      r_preset <= w_preset_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_tick_nx      = r_tick;
    w_fdiv_nx      = r_fdiv;
    w_flash_nx     = r_flash;
    w_done_nx      = 1'b0;
    w_preset_nx    = r_preset;
    w_fsm_load     = 1'b0;
    w_fsm_load_val = w_clamped;
    w_dec_en       = 1'b0;

    if (bus.clear) begin
      w_state_nx     = ST_IDLE;
      w_fsm_load     = 1'b1;
      w_fsm_load_val = '0;
      w_tick_nx      = '0;
      w_fdiv_nx      = '0;
      w_flash_nx     = 1'b0;
    end else if (bus.load && w_can_load) begin
      w_state_nx     = ST_READY;
      w_preset_nx    = w_clamped;
      w_fsm_load     = 1'b1;
      w_fsm_load_val = w_clamped;
    end else begin
      case (r_state)
        ST_READY: begin
          if (bus.start && w_nz) begin
            w_state_nx = ST_RUN;
            w_tick_nx  = '0;
          end
        end
        ST_PAUSE: begin
          // Resume keeps the partially elapsed tick.
          if (bus.start && w_nz) begin
            w_state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_nz) begin
            w_state_nx = ST_ALARM;
            w_fdiv_nx  = '0;
            w_flash_nx = 1'b0;
          end else if (bus.pause) begin
            w_state_nx = ST_PAUSE;
          end else if (r_tick == c_tick_last) begin
            w_tick_nx = '0;
            w_dec_en  = 1'b1;
            w_done_nx = w_one;
          end else begin
            w_tick_nx = r_tick + c_tick_w'(1);
          end
        end
        ST_ALARM: begin
          if (bus.start) begin
            w_state_nx     = ST_READY;
            w_fsm_load     = 1'b1;
            w_fsm_load_val = r_preset;
            w_fdiv_nx      = '0;
            w_flash_nx     = 1'b0;
          end else if (r_fdiv == c_flash_last) begin
            w_fdiv_nx  = '0;
            w_flash_nx = ~r_flash;
          end else begin
            w_fdiv_nx = r_fdiv + c_flash_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count   = w_count;
  assign bus.preset  = r_preset;
  assign bus.running = (r_state == ST_RUN);
  assign bus.alarm   = (r_state == ST_ALARM);
  assign bus.done    = r_done;
  // Flash is only ever set while in ALARM, so no state gating is needed.
  assign bus.leds    = {LED_W{r_flash}};

endmodule

`default_nettype wire
